// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM: a Moore state register plus a decoder that turns
// state, opcode, function code, zero and MIO_ready into datapath selects and strobes.
module mcpu_ctrl #(
    parameter int SEL_W = 2,
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Func,
    input  logic             zero,
    input  logic             MIO_ready,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [SEL_W-1:0] ALUSrcB,
    output logic [SEL_W-1:0] PCSource,
    output logic [SEL_W-1:0] RegDst,
    output logic [SEL_W-1:0] MemtoReg,
    output logic             ext_zero,
    output logic [ALU_W-1:0] ALU_op,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        S_IF    = 4'd0,  S_ID  = 4'd1,  S_MADDR = 4'd2,  S_MRD = 4'd3,
        S_WBLW  = 4'd4,  S_MWR = 4'd5,  S_EXR   = 4'd6,  S_WBR = 4'd7,
        S_BR    = 4'd8,  S_J   = 4'd9,  S_JAL   = 4'd10, S_EXI = 4'd11,
        S_WBI   = 4'd12
    } state_t;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'b011;
    localparam logic [ALU_W-1:0] ALU_NOR = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = '0;
        PCSource = '0;
        RegDst   = '0;
        MemtoReg = '0;
        ext_zero = 1'b0;
        ALU_op   = ALU_ADD;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = SEL_W'(1);
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
                if (MIO_ready) state_d = S_ID;
            end
            S_ID: begin
                ALUSrcB = SEL_W'(3);
                case (OP)
                    OP_LW, OP_SW:                      state_d = S_MADDR;
                    OP_RTYPE:                          state_d = S_EXR;
                    OP_BEQ, OP_BNE:                    state_d = S_BR;
                    OP_J:                              state_d = S_J;
                    OP_JAL:                            state_d = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXI;
                    default:                           state_d = S_IF;
                endcase
            end
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SEL_W'(2);
                if (OP == OP_LW)      state_d = S_MRD;
                else if (OP == OP_SW) state_d = S_MWR;
                else                  state_d = S_IF;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MIO_ready) state_d = S_WBLW;
            end
            S_WBLW: begin
                RegWrite = 1'b1;
                MemtoReg = SEL_W'(1);
                state_d  = S_IF;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MIO_ready) state_d = S_IF;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                state_d = S_WBR;
                case (Func)
                    6'b100000: ALU_op = ALU_ADD;
                    6'b100010: ALU_op = ALU_SUB;
                    6'b100100: ALU_op = ALU_AND;
                    6'b100101: ALU_op = ALU_OR;
                    6'b100110: ALU_op = ALU_XOR;
                    6'b100111: ALU_op = ALU_NOR;
                    6'b101010: ALU_op = ALU_SLT;
                    default:   state_d = S_IF;
                endcase
            end
            S_WBR: begin
                RegWrite = 1'b1;
                RegDst   = SEL_W'(1);
                state_d  = S_IF;
            end
            S_BR: begin
                // OP[0] distinguishes bne from beq, so it inverts the taken condition
                ALUSrcA  = 1'b1;
                ALU_op   = ALU_SUB;
                PCSource = SEL_W'(1);
                PCWrite  = zero ^ OP[0];
                state_d  = S_IF;
            end
            S_J: begin
                PCSource = SEL_W'(2);
                PCWrite  = 1'b1;
                state_d  = S_IF;
            end
            S_JAL: begin
                PCSource = SEL_W'(2);
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = SEL_W'(2);
                MemtoReg = SEL_W'(2);
                state_d  = S_IF;
            end
            S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SEL_W'(2);
                state_d = S_WBI;
                case (OP)
                    OP_ADDI: ALU_op = ALU_ADD;
                    OP_SLTI: ALU_op = ALU_SLT;
                    OP_ANDI: begin ALU_op = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin ALU_op = ALU_OR;  ext_zero = 1'b1; end
                    default: state_d = S_IF;
                endcase
            end
            S_WBI: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
            end
            default: begin
                ALU_op  = '0;
                state_d = S_IF;
            end
        endcase
        // Reset overrides everything so no write can slip out mid-instruction
        if (rst) begin
            state_d  = S_IF;
            IorD     = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = '0;
            PCSource = '0;
            RegDst   = '0;
            MemtoReg = '0;
            ext_zero = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_mcpu_ctrl.sv
// Randomized bench for mcpu_ctrl: each instruction is walked through its spec-defined
// state sequence while a table model predicts every output per cycle.
module tb_mcpu_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OP, Func;
    logic       zero, MIO_ready;
    logic       IorD, ALUSrcA, ext_zero, PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [2:0] ALU_op;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [18:0] ALU_MASK = 19'h7FF1F;

    mcpu_ctrl dut (
        .clk(clk), .rst(rst), .OP(OP), .Func(Func), .zero(zero), .MIO_ready(MIO_ready),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ext_zero(ext_zero), .ALU_op(ALU_op),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .state(state)
    );

    always #5 clk = ~clk;

    logic [18:0] got_v;
    assign got_v = {IorD, ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg, ext_zero, ALU_op,
                    PCWrite, IRWrite, MemRead, MemWrite, RegWrite};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit func_ok(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    endfunction

    // Output table: one row of the behaviour description per state number
    function automatic logic [18:0] exp_vec(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z, input logic mio);
        logic iord = 0, srca = 0, ez = 0, pcw = 0, irw = 0, mr = 0, mw = 0, rw = 0;
        logic [1:0] srcb = 0, pcs = 0, rd = 0, m2r = 0;
        logic [2:0] alu = 3'b010;
        case (st)
            0: begin mr = 1; srcb = 1; irw = mio; pcw = mio; end
            1: srcb = 3;
            2: begin srca = 1; srcb = 2; end
            3: begin mr = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iord = 1; end
            6: begin
                srca = 1;
                case (fn)
                    6'h22: alu = 3'b110;  6'h24: alu = 3'b000;  6'h25: alu = 3'b001;
                    6'h26: alu = 3'b011;  6'h27: alu = 3'b100;  6'h2A: alu = 3'b111;
                    default: alu = 3'b010;
                endcase
            end
            7: begin rw = 1; rd = 1; end
            8: begin srca = 1; alu = 3'b110; pcs = 1; pcw = (op == 6'b000100) ? z : !z; end
            9: begin pcs = 2; pcw = 1; end
            10: begin pcs = 2; pcw = 1; rw = 1; rd = 2; m2r = 2; end
            11: begin
                srca = 1; srcb = 2;
                if (op == 6'b001010) alu = 3'b111;
                if (op == 6'b001100) begin alu = 3'b000; ez = 1; end
                if (op == 6'b001101) begin alu = 3'b001; ez = 1; end
            end
            12: rw = 1;
            default: ;
        endcase
        return {iord, srca, srcb, pcs, rd, m2r, ez, alu, pcw, irw, mr, mw, rw};
    endfunction

    task automatic step(input int st, input logic mio);
        MIO_ready = mio;
        @(negedge clk);
        check_eq($sformatf("state_exp%0d", st), 32'(state), 32'(st));
        check_eq($sformatf("outs_s%0d_op%0h_fn%0h", st, OP, Func), 32'(got_v),
                 32'(exp_vec(st, OP, Func, zero, mio)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int s_if, input int s_mem);
        OP = op; Func = fn; zero = z;
        repeat (s_if) step(0, 1'b0);
        step(0, 1'b1);
        step(1, dc());
        case (op)
            6'b100011: begin
                step(2, dc());
                repeat (s_mem) step(3, 1'b0);
                step(3, 1'b1);
                step(4, dc());
            end
            6'b101011: begin
                step(2, dc());
                repeat (s_mem) step(5, 1'b0);
                step(5, 1'b1);
            end
            6'b000000: begin
                step(6, dc());
                if (func_ok(fn)) step(7, dc());
            end
            6'b000100, 6'b000101: step(8, dc());
            6'b000010: step(9, dc());
            6'b000011: step(10, dc());
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                step(11, dc());
                step(12, dc());
            end
            default: ;
        endcase
    endtask

    logic [5:0] op_tab [12] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03,
                                6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};
    logic [5:0] fn_tab [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h21};

    initial begin
        rst = 1'b1; OP = '0; Func = '0; zero = 1'b0; MIO_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("reset_enables", 32'(got_v & ALU_MASK), 32'd0);
            check_eq("reset_state", 32'(state), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases from the behaviour description
        run_instr(6'h23, 6'h20, 1'b0, 0, 0);
        run_instr(6'h2B, 6'h20, 1'b0, 1, 3);
        run_instr(6'h04, 6'h20, 1'b1, 0, 0);
        run_instr(6'h04, 6'h20, 1'b0, 0, 0);
        run_instr(6'h05, 6'h20, 1'b1, 0, 0);
        run_instr(6'h05, 6'h20, 1'b0, 0, 0);
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0);
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0);

        // Reset asserted while a load waits in MRD
        run_instr(6'h2B, 6'h20, 1'b0, 0, 0);
        OP = 6'h23;
        step(0, 1'b1);
        step(1, 1'b1);
        step(2, 1'b1);
        rst = 1'b1; MIO_ready = 1'b1;
        @(negedge clk);
        check_eq("midreset_state", 32'(state), 32'd3);
        check_eq("midreset_enables", 32'(got_v & ALU_MASK), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            run_instr(op_tab[$urandom_range(0, 11)],
                      ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)],
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        step(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
